// File: rtl/sqrt_arbiter.sv
// Two-requester round-robin front end for a shared square_root engine.
// Optional RUN watchdog enabled by defining SQRT_ARB_TIMEOUT_EN.
module sqrt_arbiter #(
  parameter int N       = 28,
  parameter int TIMEOUT = 32
) (
  input  logic           Clock,
  input  logic           reset,
  input  logic           rq0_valid,
  input  logic [N-1:0]   rq0_data,
  output logic           rq0_ready,
  input  logic           rq1_valid,
  input  logic [N-1:0]   rq1_data,
  output logic           rq1_ready,
  output logic           rs0_valid,
  output logic [N/2-1:0] rs0_root,
  output logic           rs0_err,
  output logic           rs1_valid,
  output logic [N/2-1:0] rs1_root,
  output logic           rs1_err,
  output logic           eng_rst_n,
  output logic [N-1:0]   eng_num,
  input  logic           eng_done,
  input  logic [N/2-1:0] eng_root,
  input  logic           eng_err
);

  localparam int H = N / 2;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    RESP = 2'd2
  } state_t;

  state_t         state_r, state_s;
  logic           last_grant_r, owner_r;
  logic           grant_s, hs_s, idle_s, neg_s, resp_owner_s, tmo_s;
  logic [H-1:0]   res_root_s;
  logic           res_err_s;

  // Round-robin pick: on contention favour whoever was not served last.
  always_comb begin
    grant_s = 1'b0;
    if (rq0_valid && rq1_valid) begin
      grant_s = ~last_grant_r;
    end else if (rq1_valid) begin
      grant_s = 1'b1;
    end else begin
      grant_s = 1'b0;
    end
  end

  assign idle_s       = (state_r == IDLE);
  assign rq0_ready    = idle_s && rq0_valid && !grant_s;
  assign rq1_ready    = idle_s && rq1_valid && grant_s;
  assign hs_s         = rq0_ready || rq1_ready;
  assign neg_s        = grant_s ? rq1_data[N-1] : rq0_data[N-1];
  assign resp_owner_s = idle_s ? grant_s : owner_r;
  assign eng_rst_n    = (state_r == RUN);

`ifdef SQRT_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] TMO_LAST = CW'(TIMEOUT - 1);
  logic [CW-1:0] tmo_cnt_r;

  // RUN-cycle counter; held at zero outside RUN so it restarts on every entry.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      tmo_cnt_r <= {CW{1'b0}};
    end else if (state_r != RUN) begin
      tmo_cnt_r <= {CW{1'b0}};
    end else begin
      tmo_cnt_r <= tmo_cnt_r + {{(CW-1){1'b0}}, 1'b1};
    end
  end

  assign tmo_s = (state_r == RUN) && (tmo_cnt_r == TMO_LAST);
`else
  // No watchdog in this build: the compare is always false for a legal TIMEOUT.
  assign tmo_s = (TIMEOUT < 32'sd0);
`endif

  // Next-state decode and the result that will be presented in RESP.
  always_comb begin
    state_s    = state_r;
    res_root_s = {H{1'b0}};
    res_err_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (hs_s && neg_s) begin
          state_s   = RESP;
          res_err_s = 1'b1;
        end else if (hs_s) begin
          state_s = RUN;
        end else begin
          state_s = IDLE;
        end
      end
      RUN: begin
        if (eng_done) begin
          state_s    = RESP;
          res_root_s = eng_root;
          res_err_s  = eng_err;
        end else if (eng_err || tmo_s) begin
          state_s   = RESP;
          res_err_s = 1'b1;
        end else begin
          state_s = RUN;
        end
      end
      RESP:    state_s = IDLE;
      default: state_s = IDLE;
    endcase
  end

  // State register, ownership pointer and engine operand capture.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      state_r      <= IDLE;
      last_grant_r <= 1'b1;
      owner_r      <= 1'b0;
      eng_num      <= {N{1'b0}};
    end else begin
      state_r <= state_s;
      if (hs_s) begin
        owner_r      <= grant_s;
        last_grant_r <= grant_s;
        eng_num      <= grant_s ? rq1_data : rq0_data;
      end else begin
        owner_r      <= owner_r;
        last_grant_r <= last_grant_r;
        eng_num      <= eng_num;
      end
    end
  end

  // Response registers: pulse valid for the owner, the other side keeps its result.
  always_ff @(posedge Clock or negedge reset) begin
    if (!reset) begin
      rs0_valid <= 1'b0;
      rs0_root  <= {H{1'b0}};
      rs0_err   <= 1'b0;
      rs1_valid <= 1'b0;
      rs1_root  <= {H{1'b0}};
      rs1_err   <= 1'b0;
    end else begin
      rs0_valid <= 1'b0;
      rs1_valid <= 1'b0;
      if (state_s == RESP && resp_owner_s) begin
        rs1_valid <= 1'b1;
        rs1_root  <= res_root_s;
        rs1_err   <= res_err_s;
      end else if (state_s == RESP) begin
        rs0_valid <= 1'b1;
        rs0_root  <= res_root_s;
        rs0_err   <= res_err_s;
      end else begin
        rs0_root <= rs0_root;
        rs0_err  <= rs0_err;
        rs1_root <= rs1_root;
        rs1_err  <= rs1_err;
      end
    end
  end

endmodule

// File: tb/tb_sqrt_arbiter.sv
// Scoreboard bench for sqrt_arbiter with a behavioural square_root engine model.
module tb_sqrt_arbiter;
  localparam int N = 28;
  localparam int H = N / 2;
  localparam int TIMEOUT = 32;

  logic Clock = 1'b0;
  logic reset = 1'b1;
  logic rqv [2];
  logic [N-1:0] rqd [2];
  logic rq0_ready, rq1_ready, rs0_valid, rs1_valid, rs0_err, rs1_err;
  logic eng_rst_n, eng_done, eng_err;
  logic [H-1:0] rs0_root, rs1_root, eng_root;
  logic [N-1:0] eng_num;

  int vectors = 0;
  int miscompares = 0;
  int cyc = 0;
  bit hang_mode = 1'b0;
  bit err_mode = 1'b0;

  typedef struct {
    int id;
    logic [H-1:0] root;
    logic err;
    int cyc;
  } exp_t;
  exp_t exp_q[$];

  // reference-side state kept by the monitor
  bit busy = 1'b0;
  bit mlast = 1'b1;
  bit run_exp = 1'b0;
  int hs_cyc = 0;
  logic [N-1:0] hs_op = '0;
  logic [H-1:0] held_root [2];
  logic held_err [2];

  sqrt_arbiter #(.N(N), .TIMEOUT(TIMEOUT)) dut (
    .Clock(Clock), .reset(reset),
    .rq0_valid(rqv[0]), .rq0_data(rqd[0]), .rq0_ready(rq0_ready),
    .rq1_valid(rqv[1]), .rq1_data(rqd[1]), .rq1_ready(rq1_ready),
    .rs0_valid(rs0_valid), .rs0_root(rs0_root), .rs0_err(rs0_err),
    .rs1_valid(rs1_valid), .rs1_root(rs1_root), .rs1_err(rs1_err),
    .eng_rst_n(eng_rst_n), .eng_num(eng_num),
    .eng_done(eng_done), .eng_root(eng_root), .eng_err(eng_err)
  );

  always #5 Clock = ~Clock;
  always @(posedge Clock) cyc <= cyc + 1;

  function automatic longint isqrt(input longint x);
    longint r;
    r = longint'($floor($sqrt(real'(x))));
    while (r * r > x) r--;
    while ((r + 1) * (r + 1) <= x) r++;
    return r;
  endfunction

  // engine: N/2 steps after release from reset, then done with the root
  int ecnt = 0;
  always @(posedge Clock) begin
    if (!eng_rst_n) begin
      ecnt <= 0;
      eng_root <= '0;
    end else if (ecnt < H) begin
      ecnt <= ecnt + 1;
      if (ecnt == H - 1) eng_root <= H'(isqrt(longint'(eng_num)));
    end
  end
  assign eng_done = !hang_mode && eng_rst_n && (ecnt == H);
  assign eng_err  = err_mode && eng_rst_n && (ecnt == 5);

  function automatic logic rdy(input int id);
    return (id != 0) ? rq1_ready : rq0_ready;
  endfunction

  // monitor / scoreboard
  initial begin
    exp_t e;
    bit resp_now;
    int hs_id, exp_g, lat;
    logic v, er;
    logic [H-1:0] r;
    logic [N-1:0] op;
    held_root[0] = '0; held_root[1] = '0; held_err[0] = 1'b0; held_err[1] = 1'b0;
    forever begin
      @(negedge Clock);
      if (!reset) begin
        exp_q.delete();
        busy = 1'b0; mlast = 1'b1;
        held_root[0] = '0; held_root[1] = '0; held_err[0] = 1'b0; held_err[1] = 1'b0;
        vectors++;
        if ({rs0_valid, rs1_valid, rs0_err, rs1_err, eng_rst_n, rs0_root, rs1_root, eng_num} != '0) begin
          miscompares++;
          $display("FAIL reset_values: rs_valid=%b%b err=%b%b eng_rst_n=%b root0=%0d root1=%0d eng_num=%0d, want all 0",
                   rs0_valid, rs1_valid, rs0_err, rs1_err, eng_rst_n, rs0_root, rs1_root, eng_num);
        end
      end else begin
        resp_now = 1'b0;
        if (rs0_valid && rs1_valid) begin
          vectors++; miscompares++;
          $display("FAIL dual_resp: both rs_valid high at cycle %0d, want at most one", cyc);
        end
        for (int id = 0; id < 2; id++) begin
          v  = (id != 0) ? rs1_valid : rs0_valid;
          r  = (id != 0) ? rs1_root : rs0_root;
          er = (id != 0) ? rs1_err : rs0_err;
          if (v) begin
            resp_now = 1'b1;
            vectors++;
            if (exp_q.size() == 0) begin
              miscompares++;
              $display("FAIL unexpected_resp: rs%0d_valid at cycle %0d root=%0d err=%b, want none", id, cyc, r, er);
            end else begin
              e = exp_q.pop_front();
              busy = 1'b0;
              held_root[e.id] = e.root; held_err[e.id] = e.err;
              if (e.id != id || e.root != r || e.err != er || e.cyc != cyc) begin
                miscompares++;
                $display("FAIL response: got id=%0d root=%0d err=%b cycle=%0d, want id=%0d root=%0d err=%b cycle=%0d",
                         id, r, er, cyc, e.id, e.root, e.err, e.cyc);
              end
            end
          end
        end
        vectors++;
        if (rs0_root != held_root[0] || rs0_err != held_err[0] || rs1_root != held_root[1] || rs1_err != held_err[1]) begin
          miscompares++;
          $display("FAIL hold: root0=%0d err0=%b root1=%0d err1=%b, want %0d %b %0d %b",
                   rs0_root, rs0_err, rs1_root, rs1_err, held_root[0], held_err[0], held_root[1], held_err[1]);
        end
        // engine sequencing: released only on the cycles between handshake and response
        vectors++;
        if (busy && run_exp && cyc > hs_cyc) begin
          if (!eng_rst_n || eng_num != hs_op) begin
            miscompares++;
            $display("FAIL engine_run: eng_rst_n=%b eng_num=%0d, want 1 and %0d", eng_rst_n, eng_num, hs_op);
          end
        end else if (eng_rst_n) begin
          miscompares++;
          $display("FAIL engine_hold: eng_rst_n=1 at cycle %0d, want 0", cyc);
        end
        if (rq0_ready && rq1_ready) begin
          vectors++; miscompares++;
          $display("FAIL dual_ready: both ready high, want at most one");
        end
        hs_id = (rqv[0] && rq0_ready) ? 0 : ((rqv[1] && rq1_ready) ? 1 : -1);
        if (!busy && !resp_now && (rqv[0] || rqv[1])) begin
          exp_g = (rqv[0] && rqv[1]) ? (mlast ? 0 : 1) : (rqv[1] ? 1 : 0);
          vectors++;
          if (hs_id != exp_g) begin
            miscompares++;
            $display("FAIL grant: accepted=%0d valid=%b%b last=%0d, want %0d", hs_id, rqv[1], rqv[0], mlast, exp_g);
          end
        end else if (hs_id >= 0) begin
          vectors++; miscompares++;
          $display("FAIL busy_accept: rq%0d accepted while busy or responding at cycle %0d", hs_id, cyc);
        end
        if (hs_id >= 0) begin
          op = (hs_id != 0) ? rqd[1] : rqd[0];
          e.id = hs_id;
          e.root = '0;
          e.err = 1'b1;
          if (op[N-1]) lat = 1;
          else if (err_mode) lat = 7;
          else if (hang_mode) begin
`ifdef SQRT_ARB_TIMEOUT_EN
            lat = TIMEOUT + 1;
`else
            lat = -1 - cyc;
`endif
          end else begin
            lat = H + 2;
            e.root = H'(isqrt(longint'(op)));
            e.err = 1'b0;
          end
          e.cyc = cyc + lat;
          exp_q.push_back(e);
          mlast = hs_id[0];
          busy = 1'b1;
          hs_cyc = cyc;
          hs_op = op;
          run_exp = !op[N-1];
        end
      end
    end
  end

  task automatic send(input int id, input logic [N-1:0] d);
    bit ok;
    ok = 1'b0;
    @(posedge Clock); #1;
    rqv[id] = 1'b1;
    rqd[id] = d;
    for (int i = 0; i < 300 && !ok; i++) begin
      @(negedge Clock);
      if (rdy(id)) ok = 1'b1;
    end
    @(posedge Clock); #1;
    rqv[id] = 1'b0;
    if (!ok) begin
      vectors++; miscompares++;
      $display("FAIL send_timeout: rq%0d data=%0d never accepted, want accept within 300 cycles", id, d);
    end
  endtask

  task automatic drain();
    bit ok;
    ok = 1'b0;
    for (int i = 0; i < 400 && !ok; i++) begin
      @(negedge Clock); #1;
      if (exp_q.size() == 0 && !busy) ok = 1'b1;
    end
    vectors++;
    if (!ok) begin
      miscompares++;
      $display("FAIL drain: %0d responses outstanding, want 0", exp_q.size());
    end
  endtask

  task automatic pulse_reset();
    @(posedge Clock); #1;
    reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1 reset = 1'b1;
  endtask

  function automatic logic [N-1:0] rand_op();
    logic [N-1:0] x;
    x = N'($urandom);
    if ($urandom_range(0, 3) == 0) x[N-1] = 1'b1;
    else x = {1'b0, x[N-2:0] >> $urandom_range(0, 26)};
    return x;
  endfunction

  initial begin
    logic [N-1:0] a, b;
    int pat;
    rqv[0] = 1'b0; rqv[1] = 1'b0; rqd[0] = '0; rqd[1] = '0;
    #2 reset = 1'b0;
    repeat (3) @(posedge Clock);
    #1 reset = 1'b1;

    send(0, N'(144)); drain();

    pulse_reset();
    fork
      send(0, N'(81));
      send(1, N'(1000000));
    join
    drain();

    send(1, 28'hFFFFFFC); drain();

    fork
      send(0, N'(134217727));
      begin @(posedge Clock); send(1, N'(12345)); end
    join
    drain();

    // reset lands in RUN cycle C5 of an in-flight operation
    send(0, N'(5000));
    repeat (4) @(posedge Clock);
    #1 reset = 1'b0;
    repeat (2) @(posedge Clock);
    #1 reset = 1'b1;
    send(0, N'(49)); drain();

    err_mode = 1'b1;
    send(1, N'(777)); drain();
    err_mode = 1'b0;

    for (int k = 0; k < 40; k++) begin
      pat = $urandom_range(0, 2);
      a = rand_op();
      b = rand_op();
      case (pat)
        0: send(0, a);
        1: send(1, b);
        default: fork send(0, a); send(1, b); join
      endcase
      repeat ($urandom_range(0, 3)) @(posedge Clock);
    end
    drain();

    hang_mode = 1'b1;
    send(0, N'(49));
`ifdef SQRT_ARB_TIMEOUT_EN
    drain();
`else
    repeat (100) @(posedge Clock);
    #1;
    vectors++;
    if (exp_q.size() != 1 || !busy) begin
      miscompares++;
      $display("FAIL hang_wait: outstanding=%0d busy=%b, want 1 and 1", exp_q.size(), busy);
    end
    pulse_reset();
`endif
    hang_mode = 1'b0;
    send(1, N'(16)); drain();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
